// File: rtl/rw_mem_pkg.sv
// rtl/rw_mem_pkg.sv - shared FSM state type and default parameters for the windowed RAM
package rw_mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int DEF_DATA_W         = 8;
   localparam int DEF_ADDR_W         = 8;
   localparam int DEF_BASE           = 128;
   localparam int DEF_DEPTH          = 96;
   localparam int DEF_CLEAR_ON_RESET = 1;

   // Word-index width; kept at least 1 so a single-word window still has a legal vector.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/rw_window_decode.sv
// rtl/rw_window_decode.sv - address window compare and word-index derivation
module rw_window_decode
   import rw_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BASE   = DEF_BASE,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
   input  logic [ADDR_W-1:0] address,
   output logic              hit,
   output logic [IDX_W-1:0]  index
);

   // One extra bit so BASE+DEPTH-1 at the top of the map cannot wrap.
   localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(BASE);
   localparam logic [ADDR_W:0] HI = (ADDR_W+1)'(BASE + DEPTH - 1);

   logic [ADDR_W:0] addr_ext;

   assign addr_ext = {1'b0, address};
   assign hit      = (addr_ext >= LO) && (addr_ext <= HI);
   assign index    = IDX_W'(address - ADDR_W'(BASE));

endmodule

// File: rtl/rw_window_ram.sv
// rtl/rw_window_ram.sv - single-port RAM mapped into an address window with optional zero-fill after reset
module rw_window_ram
   import rw_mem_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int BASE           = DEF_BASE,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              req,
   input  logic              WE,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              hit,
   output logic              err,
   output logic              busy
);

   localparam int IDX_W = idx_width(DEPTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
   localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   if ((BASE < 0) || (DEPTH < 1) || (longint'(BASE) + longint'(DEPTH) > (longint'(1) << ADDR_W))) begin : g_bad_params
      $error("rw_window_ram: window BASE..BASE+DEPTH-1 does not fit in the address space");
   end

   state_t            state_q;
   state_t            state_d;
   logic [IDX_W-1:0]  clr_cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              mem_we;
   logic              rd_en;
   logic              err_d;
   logic [DATA_W-1:0] mem [DEPTH];

   rw_window_decode #(
      .ADDR_W (ADDR_W),
      .BASE   (BASE),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_decode (
      .address (address),
      .hit     (hit),
      .index   (idx)
   );

   // The clear sequence owns the write port; bus requests are dropped while it runs.
   always_comb begin
      state_d = state_q;
      mem_we  = 1'b0;
      wr_idx  = idx;
      wr_data = data_in;
      rd_en   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         CLEAR: begin
            mem_we  = 1'b1;
            wr_idx  = clr_cnt;
            wr_data = '0;
            if (clr_cnt == LAST) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (req) begin
               if (!hit) begin
                  err_d = 1'b1;
               end else if (WE) begin
                  mem_we = 1'b1;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         default: state_d = RESET_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RESET_STATE;
         clr_cnt  <= '0;
         data_out <= '0;
         rd_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_valid <= rd_en;
         err      <= err_d;
         if (state_q == CLEAR) begin
            clr_cnt <= clr_cnt + IDX_W'(1);
         end
         if (rd_en) begin
            data_out <= mem[idx];
         end
      end
   end

   // Storage has no reset; contents change only through the clear sequence or bus writes.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign busy = (state_q == CLEAR) || (!rst_n && (CLEAR_ON_RESET != 0));

endmodule

// File: tb/tb_rw_window_ram.sv
// tb/tb_rw_window_ram.sv - directed vector bench for rw_window_ram in default and no-clear configurations
module tb_rw_window_ram;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] address;
   logic       req;
   logic       we;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       rd_valid;
   logic       hit;
   logic       err;
   logic       busy;

   logic        b_rst_n;
   logic [7:0]  b_address;
   logic        b_req;
   logic        b_we;
   logic [15:0] b_data_in;
   logic [15:0] b_data_out;
   logic        b_rd_valid;
   logic        b_hit;
   logic        b_err;
   logic        b_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rw_window_ram dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .address  (address),
      .req      (req),
      .WE       (we),
      .data_in  (data_in),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .hit      (hit),
      .err      (err),
      .busy     (busy)
   );

   rw_window_ram #(
      .DATA_W         (16),
      .ADDR_W         (8),
      .BASE           (16),
      .DEPTH          (32),
      .CLEAR_ON_RESET (0)
   ) dut_b (
      .clk      (clk),
      .rst_n    (b_rst_n),
      .address  (b_address),
      .req      (b_req),
      .WE       (b_we),
      .data_in  (b_data_in),
      .data_out (b_data_out),
      .rd_valid (b_rd_valid),
      .hit      (b_hit),
      .err      (b_err),
      .busy     (b_busy)
   );

   typedef struct {
      logic       req;
      logic       we;
      logic [7:0] addr;
      logic [7:0] din;
      logic       exp_hit;
      logic       exp_rv;
      logic       exp_err;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Called at a falling edge: drive, check hit, cross one rising edge, check registered outputs.
   task automatic apply(input vec_t v, input string name);
      req = v.req; we = v.we; address = v.addr; data_in = v.din;
      #1;
      check({name, "_hit"}, 32'(hit), 32'(v.exp_hit));
      @(negedge clk);
      check({name, "_rd_valid"}, 32'(rd_valid), 32'(v.exp_rv));
      check({name, "_err"}, 32'(err), 32'(v.exp_err));
      check({name, "_data_out"}, 32'(data_out), 32'(v.exp_dout));
      req = 1'b0;
   endtask

   task automatic b_access(input logic w, input logic [7:0] a, input logic [15:0] d);
      b_req = 1'b1; b_we = w; b_address = a; b_data_in = d;
      @(negedge clk);
      b_req = 1'b0;
   endtask

   // Returns the number of rising edges until busy drops, capped at 300.
   task automatic count_busy(output int cnt, output int noisy);
      cnt = 0;
      noisy = 0;
      while (busy && cnt < 300) begin
         req = 1'b1;
         case (cnt % 4)
            0: begin we = 1'b1; address = 8'd223; data_in = 8'h3C; end
            1: begin we = 1'b1; address = 8'd128; data_in = 8'h3C; end
            2: begin we = 1'b0; address = 8'd5; end
            default: begin we = 1'b0; address = 8'd130; end
         endcase
         @(negedge clk);
         cnt++;
         if (rd_valid || err) noisy++;
      end
      req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int noisy;

      rst_n = 1'b0; req = 1'b0; we = 1'b0; address = 8'd0; data_in = 8'd0;
      b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_address = 8'd0; b_data_in = 16'd0;

      //                req we  addr    din     hit  rv   err  dout
      vecs.push_back('{1'b1, 1'b0, 8'd128, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 8'd223, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{1'b1, 1'b1, 8'd130, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 8'd130, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5});
      vecs.push_back('{1'b0, 1'b0, 8'd130, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 8'd127, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 8'd224, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5});
      vecs.push_back('{1'b1, 1'b1, 8'd128, 8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5});
      vecs.push_back('{1'b1, 1'b1, 8'd127, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 8'd128, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A});
      vecs.push_back('{1'b1, 1'b0, 8'd129, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{1'b0, 1'b1, 8'd129, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 8'd129, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});
      vecs.push_back('{1'b1, 1'b1, 8'd255, 8'h11, 1'b0, 1'b0, 1'b1, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 8'd0,   8'h00, 1'b0, 1'b0, 1'b1, 8'h00});
      vecs.push_back('{1'b1, 1'b0, 8'd223, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00});

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_hit_addr0", 32'(hit), 32'd0);
      check("b_rst_busy", 32'(b_busy), 32'd0);

      rst_n = 1'b1;
      b_rst_n = 1'b1;
      count_busy(cnt, noisy);
      check("clear_busy_edges", 32'(cnt), 32'd96);
      check("clear_ignored_req", 32'(noisy), 32'd0);
      check("b_busy_after_rst", 32'(b_busy), 32'd0);

      foreach (vecs[i]) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the middle of clear restarts the sequence from word 0.
      apply('{1'b1, 1'b0, 8'd130, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5}, "pre_rst_read");
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_data_out", 32'(data_out), 32'd0);
      check("rst2_busy", 32'(busy), 32'd1);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("mid_clear_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(cnt, noisy);
      check("restart_busy_edges", 32'(cnt), 32'd96);
      check("restart_ignored_req", 32'(noisy), 32'd0);
      apply('{1'b1, 1'b0, 8'd128, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}, "post_restart_128");
      apply('{1'b1, 1'b0, 8'd130, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00}, "post_restart_130");

      // No-clear configuration, 16-bit words, window 16..47.
      b_access(1'b1, 8'd47, 16'hBEEF);
      check("b_wr_rd_valid", 32'(b_rd_valid), 32'd0);
      check("b_wr_data_out", 32'(b_data_out), 32'd0);
      b_access(1'b0, 8'd47, 16'h0000);
      check("b_rd47_rd_valid", 32'(b_rd_valid), 32'd1);
      check("b_rd47_data_out", 32'(b_data_out), 32'hBEEF);
      b_address = 8'd48;
      #1;
      check("b_hit_48", 32'(b_hit), 32'd0);
      b_address = 8'd16;
      #1;
      check("b_hit_16", 32'(b_hit), 32'd1);
      b_access(1'b0, 8'd48, 16'h0000);
      check("b_rd48_err", 32'(b_err), 32'd1);
      check("b_rd48_rd_valid", 32'(b_rd_valid), 32'd0);
      check("b_rd48_data_out", 32'(b_data_out), 32'hBEEF);
      b_rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("b_rst_busy2", 32'(b_busy), 32'd0);
      check("b_rst_data_out", 32'(b_data_out), 32'd0);
      b_rst_n = 1'b1;
      b_access(1'b0, 8'd47, 16'h0000);
      check("b_keep_after_rst", 32'(b_data_out), 32'hBEEF);
      check("b_keep_rd_valid", 32'(b_rd_valid), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
